// File: rtl/mvm_ctrl_pkg.sv
// Shared types and sizing helpers for the matrix-vector UART controller.
// Byte-count helpers assume every flattened bus is a whole number of bytes.
package mvm_ctrl_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    localparam int DEF_R              = 8;
    localparam int DEF_C              = 8;
    localparam int DEF_W_K            = 4;
    localparam int DEF_W_X            = 4;
    localparam int DEF_W_Y_OUT        = 16;
    localparam int DEF_BITS_PER_WORD  = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    function automatic int calc_kb(input int r, input int c, input int w_k);
        return (r * c * w_k) / 8;
    endfunction

    function automatic int calc_xb(input int c, input int w_x);
        return (c * w_x) / 8;
    endfunction

    function automatic int calc_yb(input int r, input int w_y);
        return (r * w_y) / 8;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvm_ctrl_byte_ser.sv
// Result serializer: captures the engine result and streams it out LSB byte
// first over a valid/ready interface, flagging the final handshake.
module mvm_ctrl_byte_ser
    import mvm_ctrl_pkg::*;
#(
    parameter int YB = 16,
    parameter int BW = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [YB*BW-1:0] i_data,
    output logic [BW-1:0]    o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last
);

    localparam int IW = cnt_width(YB);
    localparam logic [IW-1:0] IDX_LAST = IW'(YB - 1);

    logic [YB*BW-1:0] r_buf;
    logic [IW-1:0]    r_idx;
    logic             r_valid;
    logic [BW-1:0]    r_data;
    logic [YB*BW-1:0] w_buf_shift;
    logic             w_hs;

    // The buffer is shifted down so the next byte is always at the bottom.
    assign w_buf_shift = r_buf >> BW;
    assign w_hs        = r_valid && i_ready;
    assign o_last      = w_hs && (r_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_buf   <= i_data;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_data  <= i_data[BW-1:0];
        end else if (w_hs) begin
            if (r_idx == IDX_LAST) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_idx   <= '0;
            end else begin
                r_buf  <= w_buf_shift;
                r_data <= w_buf_shift[BW-1:0];
                r_idx  <= r_idx + IW'(1);
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/mvm_uart_ctrl.sv
// UART-side controller for a matrix-vector engine: loads K and x from a byte
// stream, starts the engine, returns y. Define MVM_RX_TIMEOUT_EN for the RX timer.
module mvm_uart_ctrl
    import mvm_ctrl_pkg::*;
#(
    parameter int R              = DEF_R,
    parameter int C              = DEF_C,
    parameter int W_K            = DEF_W_K,
    parameter int W_X            = DEF_W_X,
    parameter int W_Y_OUT        = DEF_W_Y_OUT,
    parameter int BITS_PER_WORD  = DEF_BITS_PER_WORD,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [BITS_PER_WORD-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [BITS_PER_WORD-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [R*C*W_K-1:0]       k_flat,
    output logic [C*W_X-1:0]         x_flat,
    output logic                     mvm_start,
    input  logic                     mvm_done,
    input  logic [R*W_Y_OUT-1:0]     y_flat,
    output logic                     busy,
    output logic                     rx_timeout
);

    localparam int BW = BITS_PER_WORD;
    localparam int KB = calc_kb(R, C, W_K);
    localparam int XB = calc_xb(C, W_X);
    localparam int YB = calc_yb(R, W_Y_OUT);
    localparam int NB = KB + XB;
    localparam int CW = cnt_width(NB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    generate
        if ((R * C * W_K) % 8 != 0 || (C * W_X) % 8 != 0 || (R * W_Y_OUT) % 8 != 0
            || BITS_PER_WORD != 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("mvm_uart_ctrl: K, x and y buses must be whole bytes of 8 bits");
        end
    endgenerate

    state_t        r_state;
    logic [CW-1:0] r_byte_cnt;
    logic          r_s_ready;
    logic          r_mvm_start;
    logic          r_busy;
    logic [BW-1:0] r_k_bytes [KB];
    logic [BW-1:0] r_x_bytes [XB];

    logic w_accept;
    logic w_timeout_hit;
    logic w_ser_load;
    logic w_ser_last;

    assign w_accept   = s_valid && r_s_ready;
    assign w_ser_load = (r_state == S_WAIT) && mvm_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_LOAD;
            r_byte_cnt  <= '0;
            r_s_ready   <= 1'b0;
            r_mvm_start <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_mvm_start <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_s_ready <= 1'b1;
                    if (w_timeout_hit) begin
                        r_byte_cnt <= '0;
                    end else if (w_accept) begin
                        if (r_byte_cnt == CNT_LAST) begin
                            r_byte_cnt  <= '0;
                            r_state     <= S_START;
                            r_s_ready   <= 1'b0;
                            r_mvm_start <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CW'(1);
                        end
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (mvm_done) begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_ser_last) begin
                        r_state   <= S_LOAD;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Each byte lane owns its own register; K and x persist across frames.
    for (genvar gi = 0; gi < KB; gi++) begin : g_k_bytes
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_k_bytes[gi] <= '0;
            end else if (w_accept && r_byte_cnt == CW'(gi)) begin
                r_k_bytes[gi] <= s_data;
            end
        end
        assign k_flat[gi*BW +: BW] = r_k_bytes[gi];
    end

    for (genvar gi = 0; gi < XB; gi++) begin : g_x_bytes
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_x_bytes[gi] <= '0;
            end else if (w_accept && r_byte_cnt == CW'(KB + gi)) begin
                r_x_bytes[gi] <= s_data;
            end
        end
        assign x_flat[gi*BW +: BW] = r_x_bytes[gi];
    end

`ifdef MVM_RX_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_timer;
    logic          r_rx_timeout;

    // Only idle cycles inside a partially received frame count toward the limit.
    assign w_timeout_hit = (r_state == S_LOAD) && (r_byte_cnt != '0) && !w_accept
                           && (r_timer == TMR_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_timer      <= '0;
            r_rx_timeout <= 1'b0;
        end else begin
            r_rx_timeout <= w_timeout_hit;
            if (r_state != S_LOAD || r_byte_cnt == '0 || w_accept || w_timeout_hit) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    assign rx_timeout = r_rx_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign rx_timeout    = 1'b0;
`endif

    mvm_ctrl_byte_ser #(
        .YB (YB),
        .BW (BW)
    ) u_byte_ser (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_ser_load),
        .i_data  (y_flat),
        .o_data  (m_data),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_last  (w_ser_last)
    );

    assign s_ready   = r_s_ready;
    assign mvm_start = r_mvm_start;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Directed bench for mvm_uart_ctrl at default sizes with TIMEOUT_CYCLES=16;
// the timeout scenario follows whether MVM_RX_TIMEOUT_EN is defined.
module tb_mvm_uart_ctrl;

    localparam int KB = 32;
    localparam int XB = 4;
    localparam int YB = 16;
    localparam int NB = KB + XB;

    localparam logic [127:0] Y1 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] Y2 = 128'hFEDCBA98765432100123456789ABCDEF;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_ready;
    logic [255:0] k_flat;
    logic [31:0]  x_flat;
    logic         mvm_start;
    logic         mvm_done;
    logic [127:0] y_flat;
    logic         busy;
    logic         rx_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mvm_uart_ctrl #(
        .R(8), .C(8), .W_K(4), .W_X(4), .W_Y_OUT(16),
        .BITS_PER_WORD(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .k_flat     (k_flat),
        .x_flat     (x_flat),
        .mvm_start  (mvm_start),
        .mvm_done   (mvm_done),
        .y_flat     (y_flat),
        .busy       (busy),
        .rx_timeout (rx_timeout)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_s_ready"},    256'(s_ready),    256'(0));
        check_eq({tag, "_m_valid"},    256'(m_valid),    256'(0));
        check_eq({tag, "_mvm_start"},  256'(mvm_start),  256'(0));
        check_eq({tag, "_busy"},       256'(busy),       256'(0));
        check_eq({tag, "_rx_timeout"}, 256'(rx_timeout), 256'(0));
        check_eq({tag, "_m_data"},     256'(m_data),     256'(0));
        check_eq({tag, "_k_flat"},     k_flat,           256'(0));
        check_eq({tag, "_x_flat"},     256'(x_flat),     256'(0));
    endtask

    task automatic send_frame(input logic [7:0] base);
        int t;
        s_valid = 1'b1;
        for (int i = 0; i < NB; i++) begin
            s_data = base + 8'(i);
            t = 0;
            while (!s_ready && t < 50) begin
                tick();
                t++;
            end
            if (!s_ready) check_eq("s_ready_wait", 256'(s_ready), 256'(1));
            if (i == NB - 1) check_eq("start_before_last", 256'(mvm_start), 256'(0));
            tick();
        end
        s_valid = 1'b0;
        check_eq("start_pulse", 256'(mvm_start), 256'(1));
        check_eq("s_ready_dropped", 256'(s_ready), 256'(0));
        check_eq("busy_in_start", 256'(busy), 256'(1));
        tick();
        check_eq("start_one_cycle", 256'(mvm_start), 256'(0));
        $display("[TB] frame base=%02h loaded", base);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] base);
        logic [255:0] ek;
        logic [31:0]  ex;
        ek = '0;
        ex = '0;
        for (int i = 0; i < KB; i++) ek = {8'(base + 8'(i)), ek[255:8]};
        for (int i = 0; i < XB; i++) ex = {8'(base + 8'(KB + i)), ex[31:8]};
        check_eq({tag, "_k_flat"}, k_flat, ek);
        check_eq({tag, "_x_flat"}, 256'(x_flat), 256'(ex));
    endtask

    task automatic pulse_done(input logic [127:0] y);
        y_flat   = y;
        mvm_done = 1'b1;
        tick();
        mvm_done = 1'b0;
    endtask

    task automatic recv_frame(input logic [127:0] y, input logic stall);
        logic [3:0] pat;
        logic [7:0] e;
        int j;
        int cyc;
        pat = 4'b1001;
        j   = 0;
        cyc = 0;
        while (j < YB && cyc < 300) begin
            m_ready = stall ? pat[cyc % 4] : 1'b1;
            if (m_valid) begin
                e = 8'(y >> (8 * j));
                check_eq("m_data", 256'(m_data), 256'(e));
                if (m_ready) j++;
            end
            tick();
            cyc++;
        end
        if (j < YB) check_eq("recv_bytes", 256'(j), 256'(YB));
        m_ready = 1'b0;
        check_eq("m_valid_after_send", 256'(m_valid), 256'(0));
        check_eq("s_ready_after_send", 256'(s_ready), 256'(1));
        check_eq("busy_after_send", 256'(busy), 256'(0));
        $display("[TB] result %032h received (stall=%0d)", y, stall);
    endtask

    task automatic reset_pulse(input string tag);
        rstn = 1'b0;
        #2;
        check_zero_outputs(tag);
        tick();
        rstn = 1'b1;
        tick();
        check_eq({tag, "_s_ready_up"}, 256'(s_ready), 256'(1));
        $display("[TB] reset %s applied", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        s_data   = '0;
        s_valid  = 1'b0;
        m_ready  = 1'b0;
        mvm_done = 1'b0;
        y_flat   = '0;

        repeat (3) tick();
        check_zero_outputs("por");
        rstn = 1'b1;
        tick();
        check_eq("s_ready_after_reset", 256'(s_ready), 256'(1));

        send_frame(8'h00);
        check_eq("k_byte0", 256'(k_flat[7:0]), 256'(8'h00));
        check_eq("x_flat_f1", 256'(x_flat), 256'(32'h23222120));
        check_frame("f1", 8'h00);
        check_eq("wait_busy", 256'(busy), 256'(1));
        check_eq("wait_m_valid", 256'(m_valid), 256'(0));
        pulse_done(Y1);
        recv_frame(Y1, 1'b0);

        mvm_done = 1'b1;
        tick();
        mvm_done = 1'b0;
        check_eq("done_in_load_m_valid", 256'(m_valid), 256'(0));
        check_eq("done_in_load_busy", 256'(busy), 256'(0));
        check_eq("done_in_load_s_ready", 256'(s_ready), 256'(1));
        tick();
        check_eq("done_in_load_m_valid2", 256'(m_valid), 256'(0));
        check_frame("hold", 8'h00);

        send_frame(8'h40);
        check_frame("f2", 8'h40);
        pulse_done(Y2);
        recv_frame(Y2, 1'b1);

        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 8'h80 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        pulses = 0;
        repeat (20) begin
            tick();
            if (rx_timeout) pulses++;
        end
        s_valid = 1'b1;
        s_data  = 8'h99;
        tick();
        s_valid = 1'b0;
`ifdef MVM_RX_TIMEOUT_EN
        check_eq("rx_timeout_pulses", 256'(pulses), 256'(1));
        check_eq("after_timeout_byte0", 256'(k_flat[7:0]), 256'(8'h99));
`else
        check_eq("rx_timeout_pulses", 256'(pulses), 256'(0));
        check_eq("no_timeout_byte5", 256'(k_flat[47:40]), 256'(8'h99));
        check_eq("no_timeout_byte0", 256'(k_flat[7:0]), 256'(8'h80));
`endif
        $display("[TB] partial frame test done, %0d timeout pulses", pulses);

        reset_pulse("partial");

        send_frame(8'hC0);
        check_eq("pre_wait_reset_busy", 256'(busy), 256'(1));
        reset_pulse("in_wait");

        send_frame(8'h10);
        pulse_done(Y1);
        m_ready = 1'b1;
        repeat (3) tick();
        check_eq("mid_send_m_valid", 256'(m_valid), 256'(1));
        check_eq("mid_send_m_data", 256'(m_data), 256'(8'h03));
        m_ready = 1'b0;
        reset_pulse("in_send");

        send_frame(8'h20);
        check_frame("f_post", 8'h20);
        pulse_done(Y2);
        recv_frame(Y2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mvm_uart_ctrl.md
MVM_UART_CTRL -- requirements
Module: mvm_uart_ctrl

Interface
REQ-001 SHALL have parameter R, default 8: matrix rows.
REQ-002 SHALL have parameter C, default 8: matrix columns.
REQ-003 SHALL have parameter W_K, default 4: weight width in bits.
REQ-004 SHALL have parameter W_X, default 4: vector element width in bits.
REQ-005 SHALL have parameter W_Y_OUT, default 16: result element width in bits.
REQ-006 SHALL have parameter BITS_PER_WORD, default 8: stream byte width.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 1024: RX inter-byte timeout.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic rises on it.
REQ-009 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have ports s_data (in, 8), s_valid (in, 1) and s_ready (out, 1): byte stream from the UART receiver.
REQ-011 SHALL have ports m_data (out, 8), m_valid (out, 1) and m_ready (in, 1): byte stream to the UART transmitter.
REQ-012 SHALL have port k_flat, output, R*C*W_K bits: weight matrix to the engine.
REQ-013 SHALL have port x_flat, output, C*W_X bits: vector to the engine.
REQ-014 SHALL have port mvm_start, output, 1 bit: one-cycle start pulse to the engine.
REQ-015 SHALL have port mvm_done, input, 1 bit: engine result-valid pulse.
REQ-016 SHALL have port y_flat, input, R*W_Y_OUT bits: engine result.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the state is not LOAD.
REQ-018 SHALL have port rx_timeout, output, 1 bit: one-cycle pulse when a partial frame is discarded.

Function
REQ-019 SHALL implement states LOAD, START, WAIT and SEND; transitions are LOAD->START->WAIT->SEND->LOAD.
REQ-020 SHALL require R*C*W_K, C*W_X and R*W_Y_OUT to be multiples of 8; other values are an elaboration error.
REQ-021 SHALL accept a byte only on s_valid && s_ready; s_ready is high only in LOAD.
REQ-022 SHALL load frame bytes 0..KB-1 into k_flat[8n+7:8n], LSB first, where KB=R*C*W_K/8 (32 at defaults).
REQ-023 SHALL load frame bytes KB..KB+XB-1 into x_flat, LSB first, where XB=C*W_X/8 (4 at defaults).
REQ-024 SHALL enter START on the edge that accepts the last frame byte (byte 35 at defaults), clear the byte counter and drop s_ready.
REQ-025 SHALL drive mvm_start high for exactly the one cycle spent in START, then enter WAIT.
REQ-026 SHALL in WAIT, on mvm_done=1, latch y_flat into an internal buffer and enter SEND; mvm_done SHALL be ignored in every other state.
REQ-027 SHALL in SEND hold m_valid=1 with m_data = ybuf[8j+7:8j], j starting at 0.
REQ-028 SHALL advance j on m_valid && m_ready and hold m_data stable while m_ready=0.
REQ-029 SHALL return to LOAD after the handshake of the last output byte (YB=R*W_Y_OUT/8, 16 at defaults), with m_valid=0 and s_ready=1 on the next cycle.
REQ-030 SHALL hold k_flat and x_flat until overwritten by the next frame; they are not cleared between frames.
REQ-031 SHALL register every output.

Reset
REQ-032 SHALL on rstn=0 immediately set state=LOAD, clear the byte and output counters and clear all data registers.
REQ-033 SHALL hold s_ready, m_valid, mvm_start, busy and rx_timeout at 0 and m_data, k_flat and x_flat at all-zero while rstn=0.
REQ-034 SHALL raise s_ready on the first clock edge after rstn deasserts.
REQ-035 SHALL discard any partial frame or pending transmission when reset is asserted mid-operation.

Configuration
REQ-036 SHALL, when MVM_RX_TIMEOUT_EN is defined, discard a partial frame as follows: in LOAD with byte counter != 0, TIMEOUT_CYCLES consecutive cycles without an accepted byte clear the counter and pulse rx_timeout for one cycle.
REQ-037 SHALL, when MVM_RX_TIMEOUT_EN is not defined, keep the rx_timeout port present, tie it to 0, and omit the timer.

Structure
REQ-038 SHALL define in package mvm_ctrl_pkg: the state enum, default parameter constants, and the derived KB/XB/YB byte-count functions.
REQ-039 SHALL place the output byte buffer, index and valid/ready logic in one sub-module, mvm_ctrl_byte_ser.

Verification
REQ-040 SHALL cover: reset, then 36 bytes 0x00..0x23 with s_valid held high -> k_flat[7:0]=0x00, x_flat=0x23222120, and mvm_start high exactly one cycle after the byte-35 edge.
REQ-041 SHALL cover: mvm_done with y_flat=128'h0F0E..0100 -> m_data sequence 0x00,0x01..0x0F, then s_ready=1.
REQ-042 SHALL cover: m_ready toggling 1,0,0,1 during SEND -> m_data stable while stalled, no byte lost or duplicated.
REQ-043 SHALL cover: mvm_done pulsed while in LOAD -> no state change and m_valid stays 0.
REQ-044 SHALL cover: with MVM_RX_TIMEOUT_EN and TIMEOUT_CYCLES=16, 5 bytes then 16 idle cycles -> one rx_timeout pulse, and the next byte lands in k_flat[7:0].
REQ-045 SHALL cover: rstn=0 asserted in WAIT and in SEND -> all outputs 0 immediately, and a fresh 36-byte frame then processes normally.
